// File: rtl/issue_scoreboard_ctrl_if.sv
// Decode/execute/writeback signal bundle for issue_scoreboard_ctrl.
// The master modport is the environment side; slave is the controller.
interface issue_scoreboard_ctrl_if #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   id_valid;
    logic                   id_ready;
    logic [3:0]             id_cond;
    logic [4:0]             id_opcode;
    logic [REG_W-1:0]       id_rn;
    logic [REG_W-1:0]       id_rm;
    logic [REG_W-1:0]       id_rd;
    logic [10:0]            id_imm;
    logic                   id_uses_rn;
    logic                   id_uses_rm;
    logic                   id_writes_rd;

    logic                   ex_valid;
    logic                   ex_ready;
    logic [3:0]             ex_cond;
    logic [4:0]             ex_opcode;
    logic [REG_W-1:0]       ex_rn;
    logic [REG_W-1:0]       ex_rm;
    logic [REG_W-1:0]       ex_rd;
    logic [10:0]            ex_imm;
    logic                   ex_writes_rd;

    logic                   wb_valid;
    logic [REG_W-1:0]       wb_rd;
    logic                   flush;

    logic [NUM_REGS-1:0]    pending;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_cond, id_opcode, id_rn, id_rm, id_rd, id_imm,
               id_uses_rn, id_uses_rm, id_writes_rd, ex_ready, wb_valid, wb_rd, flush,
        input  id_ready, ex_valid, ex_cond, ex_opcode, ex_rn, ex_rm, ex_rd, ex_imm,
               ex_writes_rd, pending, busy, stall_count
    );

    modport slave (
        input  id_valid, id_cond, id_opcode, id_rn, id_rm, id_rd, id_imm,
               id_uses_rn, id_uses_rm, id_writes_rd, ex_ready, wb_valid, wb_rd, flush,
        output id_ready, ex_valid, ex_cond, ex_opcode, ex_rn, ex_rm, ex_rd, ex_imm,
               ex_writes_rd, pending, busy, stall_count
    );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// ID/EX issue register with a per-register pending-write scoreboard.
// Stalls decode on RAW/WAW hazards; writeback in the same cycle bypasses the hazard.
module issue_scoreboard_ctrl #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    issue_scoreboard_ctrl_if.slave bus
);
    logic                   ex_valid_q;
    logic [3:0]             ex_cond_q;
    logic [4:0]             ex_opcode_q;
    logic [REG_W-1:0]       ex_rn_q;
    logic [REG_W-1:0]       ex_rm_q;
    logic [REG_W-1:0]       ex_rd_q;
    logic [10:0]            ex_imm_q;
    logic                   ex_writes_rd_q;
    logic [NUM_REGS-1:0]    pending_q;
    logic [NUM_REGS-1:0]    pending_d;
    logic [NUM_REGS-1:0]    wb_clear;
    logic [STALL_CNT_W-1:0] stall_q;

    logic raw_n, raw_m, waw, hazard, id_ready_c, issue, stall_inc;

    always_comb begin
        wb_clear = '0;
        if (bus.wb_valid && !rst) wb_clear[bus.wb_rd] = 1'b1;
    end

    always_comb begin
        raw_n      = bus.id_uses_rn && pending_q[bus.id_rn] && !wb_clear[bus.id_rn];
        raw_m      = bus.id_uses_rm && pending_q[bus.id_rm] && !wb_clear[bus.id_rm];
        waw        = bus.id_writes_rd && pending_q[bus.id_rd] && !wb_clear[bus.id_rd];
        hazard     = raw_n || raw_m || waw;
        id_ready_c = !rst && !bus.flush && !hazard && (!ex_valid_q || bus.ex_ready);
        issue      = bus.id_valid && id_ready_c;
        stall_inc  = bus.id_valid && !id_ready_c && !bus.flush && !rst;
    end

    // Applied lowest priority first so later writes win: wb clear, flush clear, issue set.
    always_comb begin
        pending_d = pending_q & ~wb_clear;
        if (bus.flush && ex_valid_q && ex_writes_rd_q) pending_d[ex_rd_q] = 1'b0;
        if (issue && bus.id_writes_rd) pending_d[bus.id_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_cond_q      <= '0;
            ex_opcode_q    <= '0;
            ex_rn_q        <= '0;
            ex_rm_q        <= '0;
            ex_rd_q        <= '0;
            ex_imm_q       <= '0;
            ex_writes_rd_q <= 1'b0;
            pending_q      <= '0;
            stall_q        <= '0;
        end else begin
            pending_q <= pending_d;
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (bus.flush) begin
                ex_valid_q <= 1'b0;
            end else if (issue) begin
                ex_valid_q     <= 1'b1;
                ex_cond_q      <= bus.id_cond;
                ex_opcode_q    <= bus.id_opcode;
                ex_rn_q        <= bus.id_rn;
                ex_rm_q        <= bus.id_rm;
                ex_rd_q        <= bus.id_rd;
                ex_imm_q       <= bus.id_imm;
                ex_writes_rd_q <= bus.id_writes_rd;
            end else if (ex_valid_q && bus.ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign bus.id_ready     = id_ready_c;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_cond      = ex_cond_q;
    assign bus.ex_opcode    = ex_opcode_q;
    assign bus.ex_rn        = ex_rn_q;
    assign bus.ex_rm        = ex_rm_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_writes_rd = ex_writes_rd_q;
    assign bus.pending      = pending_q;
    assign bus.busy         = !rst && (|pending_q);
    assign bus.stall_count  = stall_q;
endmodule
